nibble_word_ctrl: RTL and testbench
===================================

NIBBLE_WORD_CTRL -- requirements
Module: nibble_word_ctrl

Interface
REQ-001 SHALL have parameter NIB, default 4: nibbles per assembled word, legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000000: inactivity limit in clk cycles, legal range >= 2.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports btn_zero, btn_one, btn_commit  input  1 each  raw asynchronous push-button levels.
REQ-006 SHALL have port word_ack  input  1  consumer accepts word (synchronous to clk).
REQ-007 SHALL have port nibble  output  4  nibble under entry; last entered bit in LSB.
REQ-008 SHALL have port bit_cnt  output  3  bits entered in current nibble, 0..4.
REQ-009 SHALL have port nib_cnt  output  clog2(NIB+1)  nibbles committed to current word.
REQ-010 SHALL have port word  output  4*NIB  assembled word; first committed nibble most significant.
REQ-011 SHALL have port word_valid  output  1  word complete, awaiting word_ack.
REQ-012 SHALL have port nib_ready  output  1  four bits held, awaiting commit.
REQ-013 SHALL have ports conflict, timeout  output  1 each  single-cycle event pulses.

Function
REQ-014 SHALL synchronize each button with two flops and form a one-cycle rising-edge pulse, asserted on the 3rd clk edge after the level is first sampled high.
REQ-015 SHALL implement FSM states IDLE, COLLECT, NIB_RDY, WORD_RDY; state and outputs registered.
REQ-016 IDLE: zero/one pulse -> nibble <= {nibble[2:0],bit}, bit_cnt <= 1, go COLLECT; commit pulse ignored.
REQ-017 COLLECT: each zero/one pulse shifts the bit into the nibble LSB and increments bit_cnt; on the pulse making bit_cnt 4, go NIB_RDY.
REQ-018 NIB_RDY: nib_ready=1; bit pulses ignored; commit pulse -> word <= {word[4*NIB-5:0],nibble}, nib_cnt+1, nibble and bit_cnt cleared; go WORD_RDY if nib_cnt becomes NIB, else IDLE.
REQ-019 WORD_RDY: word_valid=1 and word stable; all button pulses ignored; on word_ack=1 -> word, nib_cnt, word_valid cleared next cycle, go IDLE.
REQ-020 word_ack outside WORD_RDY SHALL be ignored.
REQ-021 Zero and one pulses in the same cycle SHALL be discarded (no shift, no count change), with conflict pulsed 1 cycle; this holds in IDLE and COLLECT, and in NIB_RDY/WORD_RDY conflict still pulses.
REQ-022 A commit pulse in COLLECT SHALL be ignored, nibble unchanged.
REQ-023 Bit pulse to nibble/bit_cnt visible latency SHALL be exactly 1 cycle after the pulse (4 cycles after button sample).

Reset
REQ-024 reset SHALL force state IDLE and nibble, bit_cnt, nib_cnt, word, word_valid, nib_ready, conflict, timeout, synchronizer flops and timer to 0.
REQ-025 reset SHALL take priority over every event in the same cycle, including word_ack and pulses; reset mid-entry discards all partial data.
REQ-026 A button held high through reset release SHALL NOT generate a pulse.

Configuration
REQ-027 Macro NIBBLE_WORD_CTRL_TIMEOUT_EN defined: in COLLECT, TIMEOUT_CYC consecutive cycles without a bit pulse SHALL clear nibble and bit_cnt, return to IDLE and pulse timeout; any bit pulse restarts the count; word and nib_cnt are kept.
REQ-028 Macro undefined: no timer logic, timeout tied 0, COLLECT waits indefinitely.

Structure
REQ-029 Shared package syncreg_pkg SHALL hold the FSM state encoding, NIBBLE_W=4 and BIT_CNT_W=3.
REQ-030 Synchronizer plus edge detector SHALL be sub-module btn_edge_sync, instantiated three times.

Verification
REQ-031 NIB=2: bits 1,0,1,1, commit, then 0,1,1,0, commit -> word=0xB6, word_valid=1, nib_cnt=2; word_ack -> word=0, state IDLE.
REQ-032 btn_zero and btn_one rising on the same edge -> conflict pulses once, nibble=0, bit_cnt=0.
REQ-033 Bits 1,1,1,1 then btn_one pulse before commit -> nibble stays 0xF, bit_cnt=4, nib_ready=1.
REQ-034 Macro defined, TIMEOUT_CYC=10: bits 1,0 then idle 10 cycles -> timeout pulse, bit_cnt=0, nibble=0, nib_cnt unchanged.
REQ-035 reset asserted in NIB_RDY with nib_cnt=1 -> next cycle all outputs 0, state IDLE.
REQ-036 Commit in COLLECT after 2 bits -> nib_cnt unchanged, entry continues to 4 bits normally.

Source files
------------

// File: rtl/syncreg_pkg.sv
// syncreg_pkg: shared FSM encoding and field widths for the nibble/word entry controller.
package syncreg_pkg;
    localparam int NIBBLE_W  = 4;
    localparam int BIT_CNT_W = 3;
    typedef enum logic [1:0] {IDLE, COLLECT, NIB_RDY, WORD_RDY} state_t;
endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: two-flop synchronizer plus registered rising-edge pulse for one raw button.
// Ports: clk, reset (sync, active-high), btn (raw async level), pulse (one-cycle rising-edge event).
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    logic       s1, s2, s3;
    logic [2:0] arm;
    // arm[2] rises only once s3 holds a genuine post-reset sample, so a level held
    // through reset release is never mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            {s1, s2, s3, arm, pulse} <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            s3    <= s2;
            arm   <= {arm[1:0], 1'b1};
            pulse <= s2 & ~s3 & arm[2];
        end
    end
endmodule

// File: rtl/nibble_word_ctrl.sv
// nibble_word_ctrl: builds words from button-entered bits, four bits per nibble, NIB nibbles per word.
// Ports: clk, reset (sync, active-high); btn_zero/btn_one/btn_commit raw buttons; word_ack consumer accept;
//        nibble, bit_cnt, nib_cnt, word, word_valid, nib_ready status; conflict/timeout event pulses.
// Optional: define NIBBLE_WORD_CTRL_TIMEOUT_EN to abandon a partial nibble after TIMEOUT_CYC idle cycles.
module nibble_word_ctrl
    import syncreg_pkg::*;
#(
    parameter int NIB         = 4,
    parameter int TIMEOUT_CYC = 100000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btn_zero,
    input  logic                      btn_one,
    input  logic                      btn_commit,
    input  logic                      word_ack,
    output logic [NIBBLE_W-1:0]       nibble,
    output logic [BIT_CNT_W-1:0]      bit_cnt,
    output logic [$clog2(NIB+1)-1:0]  nib_cnt,
    output logic [NIBBLE_W*NIB-1:0]   word,
    output logic                      word_valid,
    output logic                      nib_ready,
    output logic                      conflict,
    output logic                      timeout
);
    localparam int WW  = NIBBLE_W * NIB;
    localparam int NCW = $clog2(NIB + 1);

    if (NIB < 2 || NIB > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("nibble_word_ctrl: illegal NIB or TIMEOUT_CYC");
    end

    logic   p_zero, p_one, p_commit;
    logic   bit_p;
    state_t state;

    btn_edge_sync u_zero   (.clk(clk), .reset(reset), .btn(btn_zero),   .pulse(p_zero));
    btn_edge_sync u_one    (.clk(clk), .reset(reset), .btn(btn_one),    .pulse(p_one));
    btn_edge_sync u_commit (.clk(clk), .reset(reset), .btn(btn_commit), .pulse(p_commit));

    // Simultaneous zero and one cancel each other; only a lone pulse is a bit.
    assign bit_p = p_zero ^ p_one;

`ifdef NIBBLE_WORD_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] timer;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            nibble     <= '0;
            bit_cnt    <= '0;
            nib_cnt    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            nib_ready  <= 1'b0;
            conflict   <= 1'b0;
            timeout    <= 1'b0;
`ifdef NIBBLE_WORD_CTRL_TIMEOUT_EN
            timer      <= '0;
`endif
        end else begin
            conflict <= p_zero & p_one;
            timeout  <= 1'b0;
`ifdef NIBBLE_WORD_CTRL_TIMEOUT_EN
            timer    <= '0;
`endif
            case (state)
                IDLE: begin
                    if (bit_p) begin
                        nibble  <= {nibble[NIBBLE_W-2:0], p_one};
                        bit_cnt <= BIT_CNT_W'(1);
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bit_p) begin
                        nibble  <= {nibble[NIBBLE_W-2:0], p_one};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_CNT_W'(NIBBLE_W - 1)) begin
                            nib_ready <= 1'b1;
                            state     <= NIB_RDY;
                        end
                    end
`ifdef NIBBLE_WORD_CTRL_TIMEOUT_EN
                    else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                        nibble  <= '0;
                        bit_cnt <= '0;
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
                NIB_RDY: begin
                    if (p_commit) begin
                        word      <= {word[WW-NIBBLE_W-1:0], nibble};
                        nib_cnt   <= nib_cnt + 1'b1;
                        nibble    <= '0;
                        bit_cnt   <= '0;
                        nib_ready <= 1'b0;
                        if (nib_cnt == NCW'(NIB - 1)) begin
                            word_valid <= 1'b1;
                            state      <= WORD_RDY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WORD_RDY: begin
                    if (word_ack) begin
                        word       <= '0;
                        nib_cnt    <= '0;
                        word_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_word_ctrl.sv
// tb_nibble_word_ctrl: scoreboard bench for nibble_word_ctrl with NIB=2, TIMEOUT_CYC=10.
module tb_nibble_word_ctrl;
    localparam int NIB = 2;
    localparam int TMO = 10;
    localparam int EV_NIB = 0, EV_WORD = 1, EV_CONF = 2, EV_TMO = 3;

    logic       clk = 1'b0, reset = 1'b1;
    logic       btn_zero = 1'b0, btn_one = 1'b0, btn_commit = 1'b0, word_ack = 1'b0;
    logic [3:0] nibble;
    logic [2:0] bit_cnt;
    logic [1:0] nib_cnt;
    logic [7:0] word;
    logic       word_valid, nib_ready, conflict, timeout;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } ev_t;
    ev_t q[$];
    int  errors = 0;
    int  checks = 0;
    logic pnr = 1'b0, pwv = 1'b0;

    nibble_word_ctrl #(.NIB(NIB), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .btn_zero(btn_zero), .btn_one(btn_one),
        .btn_commit(btn_commit), .word_ack(word_ack), .nibble(nibble),
        .bit_cnt(bit_cnt), .nib_cnt(nib_cnt), .word(word), .word_valid(word_valid),
        .nib_ready(nib_ready), .conflict(conflict), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input logic [31:0] d);
        q.push_back('{kind: k, data: d});
    endtask

    task automatic mon(input int k, input logic [31:0] d);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected none", k, d);
        end else begin
            e = q.pop_front();
            chk($sformatf("event_kind%0d", e.kind), 32'(k), 32'(e.kind));
            chk($sformatf("event_data%0d", e.kind), d, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (nib_ready && !pnr) mon(EV_NIB, 32'({bit_cnt, nibble}));
        if (word_valid && !pwv) mon(EV_WORD, 32'({nib_cnt, word}));
        if (conflict) mon(EV_CONF, 32'({bit_cnt, nibble}));
        if (timeout) mon(EV_TMO, 32'({nib_cnt, bit_cnt, nibble}));
        pnr = nib_ready;
        pwv = word_valid;
    end

    // which: 0 zero, 1 one, 2 commit, 3 zero+one together
    task automatic press(input int which);
        btn_zero   = (which == 0 || which == 3);
        btn_one    = (which == 1 || which == 3);
        btn_commit = (which == 2);
        @(negedge clk);
        {btn_zero, btn_one, btn_commit} = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    task automatic bits(input logic [3:0] b);
        for (int i = 3; i >= 0; i--) press(b[i] ? 1 : 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] all_out();
        return 32'({nibble, bit_cnt, nib_cnt, word, word_valid, nib_ready, conflict, timeout});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_state", all_out(), 32'h0);
        repeat (4) @(negedge clk);
        word_ack = 1'b1;
        @(negedge clk);
        word_ack = 1'b0;
        chk("ack_in_idle", 32'({word_valid, nib_cnt, bit_cnt}), 32'h0);
        expect_ev(EV_NIB, 32'h4B);
        bits(4'b1011);
        chk("nib_ready_b", 32'(nib_ready), 32'h1);
        press(2);
        chk("nib_cnt_1", 32'(nib_cnt), 32'h1);
        chk("cleared_after_commit", 32'({bit_cnt, nibble, nib_ready}), 32'h0);
        expect_ev(EV_NIB, 32'h46);
        bits(4'b0110);
        expect_ev(EV_WORD, 32'h2B6);
        press(2);
        chk("word_valid", 32'(word_valid), 32'h1);
        press(1);
        chk("word_hold", 32'({word, bit_cnt, nibble}), 32'({8'hB6, 7'h0}));
        word_ack = 1'b1;
        @(negedge clk);
        word_ack = 1'b0;
        chk("ack_clear", 32'({word_valid, nib_cnt, word}), 32'h0);
        press(1);
        chk("back_to_idle", 32'({bit_cnt, nibble}), 32'h11);
        do_reset();
        repeat (4) @(negedge clk);
        expect_ev(EV_CONF, 32'h0);
        press(3);
        chk("conflict_idle", 32'({bit_cnt, nibble}), 32'h0);
        press(1);
        expect_ev(EV_CONF, 32'h11);
        press(3);
        chk("conflict_collect", 32'({bit_cnt, nibble}), 32'h11);
        do_reset();
        repeat (4) @(negedge clk);
        expect_ev(EV_NIB, 32'h4F);
        bits(4'b1111);
        press(1);
        chk("nib_rdy_ignore_bit", 32'({nibble, bit_cnt, nib_ready}), 32'({4'hF, 3'd4, 1'b1}));
        do_reset();
        repeat (4) @(negedge clk);
        press(1);
        press(0);
        press(2);
        chk("commit_in_collect", 32'({nib_cnt, bit_cnt, nibble}), 32'({2'd0, 3'd2, 4'h2}));
        expect_ev(EV_NIB, 32'h49);
        press(0);
        press(1);
        press(2);
        chk("nib_cnt_after_resume", 32'(nib_cnt), 32'h1);
        expect_ev(EV_NIB, 32'h43);
        bits(4'b0011);
        chk("nib_rdy_before_reset", 32'({nib_ready, nib_cnt}), 32'h5);
        do_reset();
        chk("reset_in_nib_rdy", all_out(), 32'h0);
        btn_one = 1'b1;
        do_reset();
        repeat (8) @(negedge clk);
        chk("held_through_reset", 32'({bit_cnt, nibble}), 32'h0);
        btn_one = 1'b0;
        repeat (4) @(negedge clk);
        chk("held_release", 32'({bit_cnt, nibble}), 32'h0);
        do_reset();
        repeat (4) @(negedge clk);
        expect_ev(EV_NIB, 32'h4C);
        bits(4'b1100);
        press(2);
        press(1);
        press(0);
`ifdef NIBBLE_WORD_CTRL_TIMEOUT_EN
        expect_ev(EV_TMO, 32'h80);
        repeat (15) @(negedge clk);
        chk("after_timeout", 32'({nib_cnt, bit_cnt, nibble}), 32'({2'd1, 3'd0, 4'h0}));
`else
        repeat (15) @(negedge clk);
        chk("no_timeout", 32'({nib_cnt, bit_cnt, nibble}), 32'({2'd1, 3'd2, 4'h2}));
`endif
        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
